// File: rtl/sfx_buzzer.sv
// rtl/sfx_buzzer.sv - prioritised multi-event square-wave buzzer sound-effect generator
module sfx_buzzer #(
    parameter int                    N_EV       = 4,
    parameter int                    TICK_DIV   = 50000,
    parameter int                    HP_W       = 16,
    parameter int                    DUR_W      = 10,
    parameter logic [N_EV*HP_W-1:0]  TONE_HP    = {16'd12500, 16'd20000, 16'd25000, 16'd50000},
    parameter logic [N_EV*DUR_W-1:0] TONE_DUR   = {10'd200, 10'd30, 10'd50, 10'd500},
    parameter logic                  IDLE_LEVEL = 1'b1,
    localparam int                   CW         = (N_EV > 1) ? $clog2(N_EV) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_EV-1:0] ev_pulse,
    input  logic            mute,
    output logic            buzz_out,
    output logic            busy,
    output logic [CW-1:0]   active_ch
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    state_t            state, st_n;
    logic [CW-1:0]     cur_ch, ch_n;
    logic [HP_W-1:0]   hp_cnt, hp_n;
    logic [PW-1:0]     pre_cnt, pre_n;
    logic [DUR_W-1:0]  dur_cnt, dur_n;
    logic              tone, tone_n;
    logic              pend_v, pv_n;
    logic [CW-1:0]     pend_ch, pc_n;
    logic              buzz_q, buzz_n;

    logic [HP_W-1:0]   hp_tab  [N_EV];
    logic [DUR_W-1:0]  dur_tab [N_EV];
    logic [N_EV-1:0]   ch_en;

    for (genvar g = 0; g < N_EV; g++) begin : g_tab
        assign hp_tab[g]  = TONE_HP[g*HP_W +: HP_W];
        assign dur_tab[g] = TONE_DUR[g*DUR_W +: DUR_W];
        assign ch_en[g]   = (TONE_DUR[g*DUR_W +: DUR_W] != '0);
    end

    // Best and second-best qualified strobes; zero-duration channels never count.
    logic          has_win, has_sec;
    logic [CW-1:0] win, sec;

    always_comb begin
        has_win = 1'b0;
        has_sec = 1'b0;
        win     = '0;
        sec     = '0;
        for (int i = 0; i < N_EV; i++) begin
            if (ev_pulse[i] && ch_en[i]) begin
                if (!has_win) begin
                    has_win = 1'b1;
                    win     = CW'(i);
                end else if (!has_sec) begin
                    has_sec = 1'b1;
                    sec     = CW'(i);
                end
            end
        end
    end

    logic          fresh, cand_v, tick;
    logic [CW-1:0] fresh_ch, cand;

    always_comb begin
        st_n     = state;
        ch_n     = cur_ch;
        hp_n     = hp_cnt;
        pre_n    = pre_cnt;
        dur_n    = dur_cnt;
        tone_n   = tone;
        pv_n     = pend_v;
        pc_n     = pend_ch;
        fresh    = 1'b0;
        fresh_ch = cur_ch;
        cand_v   = 1'b0;
        cand     = '0;
        tick     = 1'b0;

        // GAP always ends in a fresh start of the queued channel unless an event overrides it.
        if (state == S_GAP) begin
            fresh = 1'b1;
        end

        if (state == S_IDLE) begin
            fresh    = has_win;
            fresh_ch = win;
            cand_v   = has_sec;
            cand     = sec;
        end else if (has_win) begin
            if (win <= cur_ch) begin
                fresh    = 1'b1;
                fresh_ch = win;
                cand_v   = has_sec;
                cand     = sec;
            end else begin
                cand_v   = 1'b1;
                cand     = win;
            end
        end

        if (cand_v && (!pend_v || cand < pend_ch)) begin
            pv_n = 1'b1;
            pc_n = cand;
        end

        if (state == S_PLAY && !fresh) begin
            if (hp_cnt == '0) begin
                tone_n = ~tone;
                hp_n   = hp_tab[cur_ch] - HP_W'(1);
            end else begin
                hp_n   = hp_cnt - HP_W'(1);
            end
            tick  = (pre_cnt == '0);
            pre_n = tick ? PW'(TICK_DIV - 1) : pre_cnt - PW'(1);
            if (tick) begin
                dur_n = dur_cnt - DUR_W'(1);
                if (dur_cnt == DUR_W'(1)) begin
                    if (pv_n) begin
                        st_n = S_GAP;
                        ch_n = pc_n;
                        pv_n = 1'b0;
                    end else begin
                        st_n = S_IDLE;
                        ch_n = '0;
                    end
                end
            end
        end

        if (fresh) begin
            st_n   = S_PLAY;
            ch_n   = fresh_ch;
            hp_n   = hp_tab[fresh_ch] - HP_W'(1);
            pre_n  = PW'(TICK_DIV - 1);
            dur_n  = dur_tab[fresh_ch];
            tone_n = 1'b1;
        end

        buzz_n = (st_n == S_PLAY && tone_n && !mute) ? ~IDLE_LEVEL : IDLE_LEVEL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cur_ch  <= '0;
            hp_cnt  <= '0;
            pre_cnt <= '0;
            dur_cnt <= '0;
            tone    <= 1'b0;
            pend_v  <= 1'b0;
            pend_ch <= '0;
            buzz_q  <= IDLE_LEVEL;
        end else begin
            state   <= st_n;
            cur_ch  <= ch_n;
            hp_cnt  <= hp_n;
            pre_cnt <= pre_n;
            dur_cnt <= dur_n;
            tone    <= tone_n;
            pend_v  <= pv_n;
            pend_ch <= pc_n;
            buzz_q  <= buzz_n;
        end
    end

    assign buzz_out  = buzz_q;
    assign busy      = (state != S_IDLE);
    assign active_ch = cur_ch;

endmodule

// File: tb/tb_sfx_buzzer.sv
// tb/tb_sfx_buzzer.sv - self-checking bench for sfx_buzzer with a timeline-based reference model
module tb_sfx_buzzer;

    localparam int TD = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] ev = 4'b0;
    logic       mute = 1'b0;
    logic       buzz_out;
    logic       busy;
    logic [1:0] active_ch;

    int n_tests = 0;
    int n_fail  = 0;

    int HP  [4] = '{5, 3, 2, 4};
    int DUR [4] = '{4, 2, 0, 3};

    sfx_buzzer #(
        .N_EV(4), .TICK_DIV(TD), .HP_W(16), .DUR_W(10),
        .TONE_HP({16'd4, 16'd2, 16'd3, 16'd5}),
        .TONE_DUR({10'd3, 10'd0, 10'd2, 10'd4}),
        .IDLE_LEVEL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ev_pulse(ev), .mute(mute),
        .buzz_out(buzz_out), .busy(busy), .active_ch(active_ch)
    );

    always #5 clk = ~clk;

    // Model: state 0 idle, 1 play, 2 gap; tone phase derived from the cycle index since start.
    int m_st = 0, m_ch = 0, m_start = 0, m_pv = 0, m_pc = 0, cyc = 0;
    bit m_mute = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_ch = 0; m_pv = 0; m_pc = 0; m_mute = 1'b0;
        end else begin
            int win, sec, cand, fresh;
            bit ending;
            win = -1; sec = -1; cand = -1; fresh = -1;
            for (int i = 0; i < 4; i++)
                if (ev[i] && DUR[i] != 0) begin
                    if (win < 0) win = i;
                    else if (sec < 0) sec = i;
                end
            ending = (m_st == 1) && (cyc == m_start + DUR[m_ch] * TD - 1);
            if (m_st == 0) begin
                fresh = win; cand = sec;
            end else begin
                if (m_st == 2) fresh = m_ch;
                if (win >= 0) begin
                    if (win <= m_ch) begin fresh = win; cand = sec; end
                    else cand = win;
                end
            end
            if (cand >= 0 && (m_pv == 0 || cand < m_pc)) begin m_pv = 1; m_pc = cand; end
            if (fresh >= 0) begin
                m_st = 1; m_ch = fresh; m_start = cyc + 1;
            end else if (ending) begin
                if (m_pv != 0) begin m_st = 2; m_ch = m_pc; m_pv = 0; end
                else begin m_st = 0; m_ch = 0; end
            end
            m_mute = mute;
            cyc = cyc + 1;
        end
    end

    function automatic logic exp_buzz();
        if (m_st == 1 && !m_mute && (((cyc - m_start) / HP[m_ch]) % 2 == 0)) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        n_tests++;
        if (busy !== (m_st != 0)) begin
            n_fail++;
            $display("FAIL model_busy cyc=%0d got=%b exp=%b", cyc, busy, (m_st != 0));
        end
        n_tests++;
        if (active_ch !== 2'(m_ch)) begin
            n_fail++;
            $display("FAIL model_active_ch cyc=%0d got=%0d exp=%0d", cyc, active_ch, m_ch);
        end
        n_tests++;
        if (buzz_out !== exp_buzz()) begin
            n_fail++;
            $display("FAIL model_buzz cyc=%0d got=%b exp=%b", cyc, buzz_out, exp_buzz());
        end
    end

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic strobe(input logic [3:0] v);
        ev = v;
        step(1);
        ev = 4'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        step(2);
        chk("reset_busy", 4'(busy), 4'd0);
        chk("reset_buzz", 4'(buzz_out), 4'd1);
        chk("reset_ch", 4'(active_ch), 4'd0);
        rst_n = 1'b1;
        step(2);

        // 1: ch1 single tone
        chk("t1_pre_busy", 4'(busy), 4'd0);
        strobe(4'b0010);
        chk("t1_busy", 4'(busy), 4'd1);
        chk("t1_ch", 4'(active_ch), 4'd1);
        chk("t1_buzz_t1", 4'(buzz_out), 4'd0);
        step(2);
        chk("t1_buzz_t3", 4'(buzz_out), 4'd0);
        step(1);
        chk("t1_buzz_t4", 4'(buzz_out), 4'd1);
        step(3);
        chk("t1_buzz_t7", 4'(buzz_out), 4'd0);
        step(13);
        chk("t1_busy_t20", 4'(busy), 4'd1);
        step(1);
        chk("t1_busy_t21", 4'(busy), 4'd0);
        chk("t1_buzz_t21", 4'(buzz_out), 4'd1);
        step(3);

        // 2: ch0 preempts ch3
        strobe(4'b1000);
        step(4);
        strobe(4'b0001);
        chk("t2_ch", 4'(active_ch), 4'd0);
        chk("t2_buzz_t1", 4'(buzz_out), 4'd0);
        step(4);
        chk("t2_buzz_t5", 4'(buzz_out), 4'd0);
        step(1);
        chk("t2_buzz_t6", 4'(buzz_out), 4'd1);
        step(34);
        chk("t2_busy_t40", 4'(busy), 4'd1);
        step(1);
        chk("t2_busy_t41", 4'(busy), 4'd0);
        step(5);
        chk("t2_no_resume", 4'(busy), 4'd0);

        // 3: pending ch1 after ch0, ch3 dropped
        strobe(4'b0001);
        step(1);
        strobe(4'b0010);
        step(2);
        strobe(4'b1000);
        step(34);
        chk("t3_ch0_t40", 4'(active_ch), 4'd0);
        step(1);
        chk("t3_gap_buzz", 4'(buzz_out), 4'd1);
        chk("t3_gap_busy", 4'(busy), 4'd1);
        step(1);
        chk("t3_ch1_ch", 4'(active_ch), 4'd1);
        chk("t3_ch1_buzz", 4'(buzz_out), 4'd0);
        step(19);
        chk("t3_ch1_t61", 4'(busy), 4'd1);
        step(1);
        chk("t3_idle_t62", 4'(busy), 4'd0);
        step(8);
        chk("t3_no_ch3", 4'(busy), 4'd0);

        // 4: zero-duration channel ignored
        strobe(4'b0100);
        chk("t4_idle_ign", 4'(busy), 4'd0);
        strobe(4'b0010);
        step(3);
        strobe(4'b0100);
        step(15);
        chk("t4_busy_t20", 4'(busy), 4'd1);
        chk("t4_ch_t20", 4'(active_ch), 4'd1);
        step(1);
        chk("t4_end_t21", 4'(busy), 4'd0);
        step(3);

        // 5: mute during ch1
        strobe(4'b0010);
        step(3);
        mute = 1'b1;
        step(3);
        chk("t5_mute_buzz", 4'(buzz_out), 4'd1);
        chk("t5_mute_busy", 4'(busy), 4'd1);
        step(4);
        mute = 1'b0;
        step(2);
        chk("t5_unmute_t13", 4'(buzz_out), 4'd0);
        step(7);
        chk("t5_busy_t20", 4'(busy), 4'd1);
        step(1);
        chk("t5_end_t21", 4'(busy), 4'd0);
        step(3);

        // 6: reset mid-play clears pending
        strobe(4'b1010);
        chk("t6_ch1", 4'(active_ch), 4'd1);
        step(4);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 4'(busy), 4'd0);
        chk("t6_rst_buzz", 4'(buzz_out), 4'd1);
        chk("t6_rst_ch", 4'(active_ch), 4'd0);
        step(2);
        rst_n = 1'b1;
        step(40);
        chk("t6_no_pending", 4'(busy), 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
